writeback_unit: RTL and testbench

- Producer side of the register-file write port: it merges results from the single-cycle ALU path and the long-latency load/MDU path into one write per cycle.
- Drives reg_write_en / rd_addr / rd_data of the register file from registered outputs.
- Keeps a 32-entry pending scoreboard for long-latency destinations and raises a read-after-write hazard for the decode-stage source addresses.

---
 rtl/writeback_unit.sv | 182 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write-port arbiter: merges single-cycle ALU results with buffered
// long-latency (load/MDU) results, tracks pending destinations and flags RAW hazards.
module writeback_unit #(
    parameter int XLEN           = 32,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_addr_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_addr_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic            issue_lsu_i,
    input  logic [4:0]      issue_rd_addr_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic            hazard_o,
    output logic            alu_hold_o,
    output logic            reg_write_en_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [31:0]     pending_o,
    output logic            err_o
);

    localparam int AW = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(LSU_FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Long-latency result buffer
    logic [4:0]      fifo_rd_mem   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_mem [LSU_FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            alu_sel;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    // Registered write port
    logic            wen_reg, wen_next;
    logic [4:0]      rd_addr_reg, rd_addr_next;
    logic [XLEN-1:0] rd_data_reg, rd_data_next;

    // Scoreboard, starvation and error state
    logic [31:0]     pending_reg, pending_next;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;
    logic [SW-1:0]   starve_reg, starve_next;
    logic            hold_reg, hold_next;
    logic            err_reg, err_next;
    logic            issue_conflict;
    logic            hold_violation;

    assign fifo_full   = (count_reg == CW'(LSU_FIFO_DEPTH));
    assign fifo_empty  = (count_reg == '0);
    assign lsu_ready_o = !fifo_full;
    assign push        = lsu_valid_i && !fifo_full;

    // A registered hold suppresses the ALU, which forces the FIFO head out.
    assign alu_sel     = alu_valid_i && !hold_reg;
    assign pop         = !alu_sel && !fifo_empty;

    assign head_rd     = fifo_rd_mem[rd_ptr_reg];
    assign head_data   = fifo_data_mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= lsu_rd_addr_i;
            fifo_data_mem[wr_ptr_reg] <= lsu_data_i;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // rd=0 selections are consumed but leave the address/data registers untouched.
    always_comb begin
        wen_next     = 1'b0;
        rd_addr_next = rd_addr_reg;
        rd_data_next = rd_data_reg;
        if (alu_sel) begin
            if (alu_rd_addr_i != 5'd0) begin
                wen_next     = 1'b1;
                rd_addr_next = alu_rd_addr_i;
                rd_data_next = alu_data_i;
            end
        end else if (pop && (head_rd != 5'd0)) begin
            wen_next     = 1'b1;
            rd_addr_next = head_rd;
            rd_data_next = head_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_sb
            assign set_vec[gi] = issue_lsu_i && (issue_rd_addr_i == 5'(gi));
            assign clr_vec[gi] = pop && (head_rd == 5'(gi));
        end
    endgenerate

    // Set is applied after clear so a same-cycle reissue keeps the bit; x0 never pends.
    assign pending_next = ((pending_reg & ~clr_vec) | set_vec) & ~32'd1;

    assign issue_conflict = issue_lsu_i && (issue_rd_addr_i != 5'd0) && pending_reg[issue_rd_addr_i];
    assign hold_violation = alu_valid_i && hold_reg;
    assign err_next       = err_reg | issue_conflict | hold_violation;

    // Reaching the limit arms a one-cycle hold and restarts the count.
    always_comb begin
        starve_next = '0;
        hold_next   = 1'b0;
        if (fifo_full && alu_sel) begin
            if (starve_reg == SW'(STARVE_LIMIT - 1)) begin
                hold_next = 1'b1;
            end else begin
                starve_next = starve_reg + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            wen_reg     <= 1'b0;
            rd_addr_reg <= '0;
            rd_data_reg <= '0;
            pending_reg <= '0;
            starve_reg  <= '0;
            hold_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            wen_reg     <= wen_next;
            rd_addr_reg <= rd_addr_next;
            rd_data_reg <= rd_data_next;
            pending_reg <= pending_next;
            starve_reg  <= starve_next;
            hold_reg    <= hold_next;
            err_reg     <= err_next;
        end
    end

    assign hazard_o = ((rs1_addr_i != 5'd0) && pending_reg[rs1_addr_i]) ||
                      ((rs2_addr_i != 5'd0) && pending_reg[rs2_addr_i]);

    assign alu_hold_o     = hold_reg;
    assign reg_write_en_o = wen_reg;
    assign rd_addr_o      = rd_addr_reg;
    assign rd_data_o      = rd_data_reg;
    assign pending_o      = pending_reg;
    assign err_o          = err_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_writeback_unit;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard_o;
    logic        alu_hold_o;
    logic        reg_write_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [31:0] pending_o;
    logic        err_o;

    writeback_unit #(
        .XLEN(32),
        .LSU_FIFO_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .alu_valid_i(alu_valid),
        .alu_rd_addr_i(alu_rd),
        .alu_data_i(alu_data),
        .lsu_valid_i(lsu_valid),
        .lsu_ready_o(lsu_ready_o),
        .lsu_rd_addr_i(lsu_rd),
        .lsu_data_i(lsu_data),
        .issue_lsu_i(issue),
        .issue_rd_addr_i(issue_rd),
        .rs1_addr_i(rs1),
        .rs2_addr_i(rs2),
        .hazard_o(hazard_o),
        .alu_hold_o(alu_hold_o),
        .reg_write_en_o(reg_write_en_o),
        .rd_addr_o(rd_addr_o),
        .rd_data_o(rd_data_o),
        .pending_o(pending_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model state
    ent_t        mq[$];
    logic [31:0] m_pending;
    bit          m_hold;
    bit          m_err;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_run;

    logic [36:0] wr_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_pending = '0;
        m_hold = 1'b0;
        m_err = 1'b0;
        m_wen = 1'b0;
        m_rd = '0;
        m_data = '0;
        m_run = 0;
    endtask

    // One clock cycle with the currently driven inputs; called at posedge+1.
    task automatic tick();
        bit   full;
        bit   alu_take;
        bit   pop;
        bit   push;
        bit   hold_n;
        bit   exp_haz;
        ent_t head;
        #1;
        full    = (mq.size() == DEPTH);
        exp_haz = ((rs1 != 0) && m_pending[rs1]) || ((rs2 != 0) && m_pending[rs2]);
        check("lsu_ready", lsu_ready_o, !full);
        check("alu_hold", alu_hold_o, m_hold);
        check("hazard", hazard_o, exp_haz);

        alu_take = alu_valid && !m_hold;
        pop      = !alu_take && (mq.size() != 0);
        push     = lsu_valid && !full;
        head     = pop ? mq[0] : '0;

        if (issue && issue_rd != 0 && m_pending[issue_rd]) m_err = 1'b1;
        if (alu_valid && m_hold) m_err = 1'b1;

        m_wen = 1'b0;
        if (alu_take) begin
            if (alu_rd != 0) begin m_wen = 1'b1; m_rd = alu_rd; m_data = alu_data; end
        end else if (pop && head.rd != 0) begin
            m_wen = 1'b1; m_rd = head.rd; m_data = head.data;
        end

        if (pop && head.rd != 0) m_pending[head.rd] = 1'b0;
        if (issue && issue_rd != 0) m_pending[issue_rd] = 1'b1;

        hold_n = 1'b0;
        if (full && alu_take) begin
            m_run++;
            if (m_run == LIMIT) begin hold_n = 1'b1; m_run = 0; end
        end else begin
            m_run = 0;
        end

        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{rd: lsu_rd, data: lsu_data});

        @(posedge clk_i);
        #1;
        m_hold = hold_n;
        check("wen", reg_write_en_o, m_wen);
        check("rd_addr", rd_addr_o, m_rd);
        check("rd_data", rd_data_o, m_data);
        check("pending", pending_o, m_pending);
        check("err", err_o, m_err);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_wen", reg_write_en_o, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_pending", pending_o, 0);
        check("rst_err", err_o, 0);
        check("rst_hold", alu_hold_o, 0);
        check("rst_ready", lsu_ready_o, 1);
        check("rst_hazard", hazard_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        model_reset();
        #2;
        do_reset();

        // ALU write with nonzero and zero destination
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        tick();
        check("alu_wen", reg_write_en_o, 1);
        check("alu_rd", rd_addr_o, 3);
        check("alu_data", rd_data_o, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h1234;
        tick();
        check("alu_x0_wen", reg_write_en_o, 0);
        check("alu_x0_hold_data", rd_data_o, 32'hDEADBEEF);
        idle();

        // Scoreboard and RAW hazard
        issue = 1'b1; issue_rd = 5'd7;
        tick();
        idle(); rs1 = 5'd7;
        #1;
        check("raw_hazard_set", hazard_o, 1);
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h55;
        tick();
        lsu_valid = 1'b0;
        tick();
        check("lsu_wen", reg_write_en_o, 1);
        check("lsu_rd", rd_addr_o, 7);
        check("lsu_data", rd_data_o, 32'h55);
        check("lsu_clear", pending_o[7], 0);
        #1;
        check("raw_hazard_drop", hazard_o, 0);
        idle();
        issue = 1'b1; issue_rd = 5'd7;
        tick();
        idle(); lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h66;
        tick();
        idle(); issue = 1'b1; issue_rd = 5'd7;
        tick();
        check("set_wins_pending", pending_o[7], 1);
        check("set_wins_write", rd_data_o, 32'h66);
        idle();
        do_reset();

        // Contention and starvation hold
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h111;
        tick();
        alu_rd = 5'd21; alu_data = 32'hA1;
        lsu_rd = 5'd2; lsu_data = 32'h222;
        tick();
        lsu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_rd = 5'(22 + i); alu_data = 32'hB0 + 32'(i);
            #1;
            check("cont_hold_low", alu_hold_o, 0);
            tick();
            check("cont_alu_win", rd_addr_o, 64'(22 + i));
        end
        alu_rd = 5'd26; alu_data = 32'hC6;
        #1;
        check("cont_hold_high", alu_hold_o, 1);
        tick();
        check("cont_pop_rd", rd_addr_o, 1);
        check("cont_pop_data", rd_data_o, 32'h111);
        check("cont_err", err_o, 1);
        alu_rd = 5'd27; alu_data = 32'hC7;
        tick();
        check("cont_after_hold", rd_addr_o, 27);
        idle();
        tick();
        tick();
        do_reset();

        // Backpressure and ordering
        wr_log.delete();
        alu_valid = 1'b1; alu_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h1010;
        tick();
        lsu_rd = 5'd11; lsu_data = 32'h1111;
        tick();
        lsu_rd = 5'd12; lsu_data = 32'h1212;
        #1;
        check("bp_ready_low", lsu_ready_o, 0);
        tick();
        tick();
        alu_valid = 1'b0;
        tick();
        if (reg_write_en_o) wr_log.push_back({rd_addr_o, rd_data_o});
        tick();
        if (reg_write_en_o) wr_log.push_back({rd_addr_o, rd_data_o});
        idle();
        tick();
        if (reg_write_en_o) wr_log.push_back({rd_addr_o, rd_data_o});
        tick();
        if (reg_write_en_o) wr_log.push_back({rd_addr_o, rd_data_o});
        check("bp_count", wr_log.size(), 3);
        while (wr_log.size() < 3) wr_log.push_back('0);
        check("bp_first", wr_log[0], {5'd10, 32'h1010});
        check("bp_second", wr_log[1], {5'd11, 32'h1111});
        check("bp_third", wr_log[2], {5'd12, 32'h1212});
        do_reset();

        // Double issue sets a sticky error
        issue = 1'b1; issue_rd = 5'd9;
        tick();
        check("dbl_first_ok", err_o, 0);
        tick();
        check("dbl_err", err_o, 1);
        idle();
        for (int i = 0; i < 3; i++) tick();
        check("dbl_sticky", err_o, 1);
        do_reset();

        // Reset mid-stream with two buffered entries and pending[5]
        issue = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h1313;
        tick();
        issue = 1'b0;
        lsu_rd = 5'd14; lsu_data = 32'h1414;
        tick();
        rs1 = 5'd5; lsu_valid = 1'b0;
        #1;
        check("mid_pending5", pending_o[5], 1);
        check("mid_full", lsu_ready_o, 0);
        check("mid_hazard", hazard_o, 1);
        do_reset();
        tick();
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            alu_valid = !m_hold && ($urandom_range(0, 9) < 6);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 9) < 5);
            lsu_rd    = 5'($urandom_range(0, 31));
            lsu_data  = $urandom;
            issue_rd  = 5'($urandom_range(0, 31));
            issue     = ($urandom_range(0, 9) < 3) && !m_pending[issue_rd];
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
